control_pipeline: RTL

- Parametrised successor to the single-cycle opcode decoder: decodes the ID-stage opcode and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Generates the front-end stall and flush signals for three cases: load-use hazards, taken branches and jumps, and multi-cycle floating-point ops that hold EX for FP_LATENCY cycles.
- Sits between the IF/ID register and the datapath stage registers, and replaces per-stage control plumbing.

---
 rtl/control_pipeline.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/control_pipeline.sv
// Opcode decode plus ID/EX, EX/MEM and MEM/WB control registers.
// Generates front-end stall/flush for load-use, branch/jump and multi-cycle float ops.
module control_pipeline #(
  parameter int OPCODE_W   = 6,
  parameter int ALUOP_W    = 4,
  parameter int REG_ADDR_W = 5,
  parameter int FP_LATENCY = 4,
  parameter int LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_zero,
  output logic                  stall_id,
  output logic                  flush_ifid,
  output logic                  branch_taken,
  output logic                  ex_alusrc,
  output logic                  ex_issigned,
  output logic                  ex_floatop,
  output logic                  ex_beq,
  output logic                  ex_bne,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic                  wb_link,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic [REG_ADDR_W-1:0] mem_dst,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic                  illegal_op
);

  localparam int CNT_W = (FP_LATENCY > 1) ? $clog2(FP_LATENCY) : 1;
  localparam logic [CNT_W-1:0] FP_LOAD = CNT_W'(FP_LATENCY - 1);

  localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'('h00);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'('h02);
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'('h03);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'('h04);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'('h05);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'('h07);
  localparam logic [OPCODE_W-1:0] OP_ADDIU = OPCODE_W'('h08);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'('h09);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'('h0c);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'('h0e);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'('h0f);
  localparam logic [OPCODE_W-1:0] OP_FLOAT = OPCODE_W'('h11);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'('h12);
  localparam logic [OPCODE_W-1:0] OP_LBU   = OPCODE_W'('h22);
  localparam logic [OPCODE_W-1:0] OP_SB    = OPCODE_W'('h28);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'('h2b);

  typedef struct packed {
    logic                  aluSrc;
    logic                  isSigned;
    logic                  floatOp;
    logic                  beq;
    logic                  bne;
    logic [ALUOP_W-1:0]    aluOp;
    logic                  memRead;
    logic                  memWrite;
    logic                  regWrite;
    logic                  memToReg;
    logic                  link;
    logic                  illegal;
    logic [REG_ADDR_W-1:0] dst;
  } ExCtrl;

  typedef struct packed {
    logic                  memRead;
    logic                  memWrite;
    logic                  regWrite;
    logic                  memToReg;
    logic                  link;
    logic [REG_ADDR_W-1:0] dst;
  } MemCtrl;

  typedef struct packed {
    logic                  regWrite;
    logic                  memToReg;
    logic                  link;
    logic [REG_ADDR_W-1:0] dst;
  } WbCtrl;

  ExCtrl           dec;
  logic            idReadsRt;
  logic            idJump;
  ExCtrl           exReg;
  MemCtrl          memReg;
  WbCtrl           wbReg;
  MemCtrl          exToMem;
  WbCtrl           memToWb;
  logic [CNT_W-1:0] fpCnt;
  logic            branchTaken;
  logic            fpBusy;
  logic            loadUse;

  // Opcode decode; unknown opcodes behave as nops but remember they were illegal.
  always_comb begin
    dec       = '0;
    idReadsRt = 1'b0;
    idJump    = 1'b0;
    if (id_valid) begin
      case (id_opcode)
        OP_NOP: begin
        end
        OP_LW, OP_LBU: begin
          dec.regWrite = 1'b1;
          dec.memToReg = 1'b1;
          dec.memRead  = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.isSigned = 1'b1;
          dec.dst      = id_rt;
        end
        OP_SB, OP_SW: begin
          dec.memWrite = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.isSigned = 1'b1;
          idReadsRt    = 1'b1;
        end
        OP_RTYPE: begin
          dec.regWrite = 1'b1;
          dec.aluOp    = ALUOP_W'(2);
          dec.dst      = id_rd;
          idReadsRt    = 1'b1;
        end
        OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: begin
          dec.regWrite = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.dst      = id_rt;
          case (id_opcode)
            OP_LUI:  dec.aluOp = ALUOP_W'(1);
            OP_ADDI: dec.aluOp = ALUOP_W'(4);
            OP_ANDI: dec.aluOp = ALUOP_W'(5);
            OP_ORI:  dec.aluOp = ALUOP_W'(3);
            default: dec.aluOp = ALUOP_W'(0);
          endcase
        end
        OP_BEQ, OP_BNE: begin
          dec.beq   = (id_opcode == OP_BEQ);
          dec.bne   = (id_opcode == OP_BNE);
          dec.aluOp = ALUOP_W'(7);
          idReadsRt = 1'b1;
        end
        OP_J: begin
          idJump = 1'b1;
        end
        OP_JAL: begin
          idJump       = 1'b1;
          dec.regWrite = 1'b1;
          dec.link     = 1'b1;
          dec.dst      = REG_ADDR_W'(LINK_REG);
        end
        OP_FLOAT: begin
          dec.floatOp  = 1'b1;
          dec.regWrite = 1'b1;
          dec.aluOp    = ALUOP_W'(8);
          dec.dst      = id_rd;
          idReadsRt    = 1'b1;
        end
        default: begin
          dec.illegal = 1'b1;
        end
      endcase
    end
    if (dec.dst == '0) begin
      dec.regWrite = 1'b0;
    end
  end

  always_comb begin
    exToMem = '{memRead: exReg.memRead, memWrite: exReg.memWrite, regWrite: exReg.regWrite,
                memToReg: exReg.memToReg, link: exReg.link, dst: exReg.dst};
    memToWb = '{regWrite: memReg.regWrite, memToReg: memReg.memToReg, link: memReg.link,
                dst: memReg.dst};
  end

  // Hazard priority: taken branch, then float hold, then load-use, then jump in ID.
  always_comb begin
    branchTaken = (exReg.beq & ex_zero) | (exReg.bne & ~ex_zero);
    fpBusy      = (fpCnt != '0);
    loadUse     = exReg.memRead & (exReg.dst != '0) &
                  ((exReg.dst == id_rs) | (idReadsRt & (exReg.dst == id_rt)));
    stall_id    = ~branchTaken & (fpBusy | loadUse);
    flush_ifid  = rst_n & (branchTaken | (~fpBusy & ~loadUse & idJump));
  end

  // Stage registers; a float op parks in EX while fpCnt drains, feeding bubbles to MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exReg  <= '0;
      memReg <= '0;
      wbReg  <= '0;
      fpCnt  <= '0;
    end else begin
      wbReg <= memToWb;
      if (branchTaken) begin
        exReg  <= '0;
        memReg <= exToMem;
      end else if (fpBusy) begin
        memReg <= '0;
        fpCnt  <= fpCnt - CNT_W'(1);
      end else if (loadUse) begin
        exReg  <= '0;
        memReg <= exToMem;
      end else begin
        exReg  <= dec;
        memReg <= exToMem;
        if (dec.floatOp) begin
          fpCnt <= FP_LOAD;
        end
      end
    end
  end

  assign branch_taken = branchTaken;
  assign ex_alusrc    = exReg.aluSrc;
  assign ex_issigned  = exReg.isSigned;
  assign ex_floatop   = exReg.floatOp;
  assign ex_beq       = exReg.beq;
  assign ex_bne       = exReg.bne;
  assign ex_aluop     = exReg.aluOp;
  assign ex_dst       = exReg.dst;
  assign illegal_op   = exReg.illegal;
  assign mem_read     = memReg.memRead;
  assign mem_write    = memReg.memWrite;
  assign mem_dst      = memReg.dst;
  assign wb_regwrite  = wbReg.regWrite;
  assign wb_memtoreg  = wbReg.memToReg;
  assign wb_link      = wbReg.link;
  assign wb_dst       = wbReg.dst;

endmodule
